div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Multi-cycle control stage wrapped around the team's combinational 32-bit unsigned restoring divide array.
- Upstream side: accepts operands from the datapath and converts signed operands to magnitudes, which it presents to the array.
- Downstream side: after a settle window, captures the array's quotient and remainder, applies sign correction, and writes the HI/LO result registers.
- Supplies the start/busy/done handshake the control unit uses for DIV instructions.

Parameters:
- WIDTH, 32, operand/result width (array is 32-bit; only 32 supported).
- SETTLE_CYCLES, 2, cycles the array inputs are held stable before capture; legal range 1..15.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned.
- dividend  input  32  numerator, sampled with start.
- divisor  input  32  denominator, sampled with start.
- core_q  output  32  dividend magnitude to the array's Q input (registered).
- core_m  output  32  divisor magnitude to the array's Mi input (registered).
- core_result  input  32  array quotient.
- core_remainder  input  32  array remainder.
- busy  output  1  high in WAIT and FIX.
- done  output  1  one-cycle pulse, high in DONE.
- div_by_zero  output  1  set when a zero divisor is accepted.
- lo_out  output  32  quotient register (LO).
- hi_out  output  32  remainder register (HI).

Behaviour:
- Reset (clear=0, asynchronous):
  - state=IDLE.
  - core_q, core_m, lo_out, hi_out = 0.
  - busy, done, div_by_zero = 0.
  - settle counter = 0.
  - Reset mid-operation aborts it and no result is written.
- States: IDLE, WAIT, FIX, DONE (2-bit encoding).
- IDLE / DONE with start=1:
  - Latch q_neg = signed_op & (dividend[31] ^ divisor[31]).
  - Latch r_neg = signed_op & dividend[31].
  - core_q = (signed_op & dividend[31]) ? -dividend : dividend; likewise core_m from divisor.
  - Magnitude of 0x80000000 is 0x80000000 (unsigned view).
  - Clear div_by_zero.
  - If divisor==0: go to DONE; div_by_zero=1; lo_out=0xFFFFFFFF; hi_out=dividend, unmodified regardless of signed_op.
  - Otherwise: go to WAIT with counter=SETTLE_CYCLES-1.
- IDLE / DONE with start=0: go to / stay in IDLE.
- WAIT: core_q and core_m are held; counter decrements each cycle; go to FIX when counter==0 (WAIT lasts SETTLE_CYCLES cycles).
- FIX, single cycle:
  - lo_out = q_neg ? -core_result : core_result.
  - hi_out = r_neg ? -core_remainder : core_remainder.
  - Both written on the edge leaving FIX. Next state is DONE.
- DONE: done=1 for exactly one cycle. A start in this cycle is accepted identically to IDLE (back-to-back ops).
- Latency:
  - Nonzero divisor: done high SETTLE_CYCLES+2 cycles after the start-sampling edge (4 with default).
  - Zero divisor: done high 1 cycle after that edge.
- start while busy=1 is ignored; operands are not re-sampled.
- lo_out, hi_out and div_by_zero hold their values until the next accepted start (flag) or next write (HI/LO).
- Arithmetic: all negation is 32-bit two's complement, wrapping. Signed 0x80000000 / 0xFFFFFFFF yields lo_out=0x80000000, hi_out=0, no flag.
- Remainder sign follows the dividend; quotient truncates toward zero.

Test Plan:
- Unsigned 100/7, SETTLE_CYCLES=2 -> done 4 cycles after start; lo_out=0x0000000E, hi_out=0x00000002; busy high for 3 cycles.
- Signed -7/2 (0xFFFFFFF9/0x00000002) -> core_q=7, core_m=2; lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
- Signed 7/-2 -> lo_out=0xFFFFFFFD, hi_out=0x00000001. Unsigned 0xFFFFFFF9/2 -> lo_out=0x7FFFFFFC, hi_out=1.
- Divide-by-zero, dividend=0x00001234, divisor=0 -> done 1 cycle after start, div_by_zero=1, lo_out=0xFFFFFFFF, hi_out=0x00001234. Next valid start clears the flag.
- Overflow case: signed 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0, div_by_zero=0.
- Control edge cases:
  - Second start pulsed while busy (20/3) is ignored; the first result stands.
  - start held through DONE launches the next op back-to-back.
  - clear driven low during WAIT -> all outputs 0 immediately; a following 9/3 completes normally with lo_out=3, hi_out=0.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer
//   Multi-cycle control stage around the combinational 32-bit unsigned
//   restoring divide array. It takes operands and turns signed operands into
//   magnitudes for the array. It waits a settle window, then captures the
//   quotient and remainder, applies sign correction and writes HI/LO.
//
// Ports
//   clock          : system clock, rising edge
//   clear          : asynchronous active-low reset
//   start          : request, sampled only while busy=0
//   signed_op      : 1 = two's-complement divide, 0 = unsigned
//   dividend       : numerator, sampled with start
//   divisor        : denominator, sampled with start
//   core_q         : registered dividend magnitude to the array Q input
//   core_m         : registered divisor magnitude to the array Mi input
//   core_result    : array quotient
//   core_remainder : array remainder
//   busy           : high while waiting on / correcting the array result
//   done           : one-cycle completion pulse
//   div_by_zero    : set when a zero divisor is accepted
//   lo_out         : quotient register (LO)
//   hi_out         : remainder register (HI)
module div_sequencer #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] core_q,
    output logic [WIDTH-1:0] core_m,
    input  logic [WIDTH-1:0] core_result,
    input  logic [WIDTH-1:0] core_remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] core_q_q, core_q_d;
    logic [WIDTH-1:0] core_m_q, core_m_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        core_q_d = core_q_q;
        core_m_d = core_m_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        dbz_d    = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    q_neg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d  = signed_op & dividend[WIDTH-1];
                    // 0x80000000 negates to itself, which is its correct unsigned magnitude
                    core_q_d = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
                    core_m_d = (signed_op & divisor[WIDTH-1])  ? -divisor  : divisor;
                    dbz_d    = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                        lo_d    = '1;
                        hi_d    = dividend;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_FIX: begin
                lo_d    = q_neg_q ? -core_result : core_result;
                hi_d    = r_neg_q ? -core_remainder : core_remainder;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            core_q_q <= '0;
            core_m_q <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            core_q_q <= core_q_d;
            core_m_q <= core_m_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign core_q      = core_q_q;
    assign core_m      = core_m_q;
    assign lo_out      = lo_q;
    assign hi_out      = hi_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == S_WAIT) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);

endmodule
